vxe_vpu_cmd_dispatch: RTL and testbench



---
 rtl/vxe_vpu_cmd_dispatch.sv | 150 +++++++++++++++
 tb/tb_vxe_vpu_cmd_dispatch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vxe_vpu_cmd_dispatch.sv
// vxe_vpu_cmd_dispatch
// VPU-side receiver of the CU->VPU command bus. Commands {op, th, pl} are
// accepted on the sel/ack bus and sorted into small per-thread circular FIFOs.
// Each thread pipe pops its own queue through a vld/rd handshake.
// Optional build macro: VXE_VPU_CMD_BCAST_EN (th==7 broadcasts to all queues).
module vxe_vpu_cmd_dispatch #(
    parameter int NTHR        = 8,
    parameter int QDEPTH_POW2 = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_vpu_cmd_sel,
    output logic                 o_vpu_cmd_ack,
    input  logic [4:0]           i_vpu_cmd_op,
    input  logic [2:0]           i_vpu_cmd_th,
    input  logic [47:0]          i_vpu_cmd_pl,
    output logic [NTHR-1:0]      o_th_cmd_vld,
    output logic [5*NTHR-1:0]    o_th_cmd_op,
    output logic [48*NTHR-1:0]   o_th_cmd_pl,
    input  logic [NTHR-1:0]      i_th_cmd_rd,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int DEPTH = 1 << QDEPTH_POW2;
    localparam int CW    = QDEPTH_POW2 + 1;
    localparam int PW    = QDEPTH_POW2;

    typedef struct packed {
        logic [4:0]  op;
        logic [47:0] pl;
    } entry_t;

    entry_t            mem_q  [NTHR][DEPTH];
    logic [PW-1:0]     wptr_q [NTHR];
    logic [PW-1:0]     rptr_q [NTHR];
    logic [CW-1:0]     cnt_q  [NTHR];
    logic [CW-1:0]     cnt_d  [NTHR];
    logic [NTHR-1:0]   full;
    logic [NTHR-1:0]   vld;
    logic [NTHR-1:0]   push;
    logic [NTHR-1:0]   pop;
    logic [NTHR-1:0]   nonempty_d;
    logic              busy_q;
    logic              err_q;
    logic              err_d;
    logic              th_valid;
    logic              tgt_full;
    logic              xfer;
    logic [3:0]        th_ext;

    assign th_ext   = {1'b0, i_vpu_cmd_th};
    assign th_valid = (th_ext < 4'(NTHR));
    assign xfer     = i_vpu_cmd_sel & o_vpu_cmd_ack;

    // Queue status flags, derived from the registered counts only
    always_comb begin
        full = '0;
        vld  = '0;
        for (int n = 0; n < NTHR; n++) begin
            full[n] = (cnt_q[n] == CW'(DEPTH));
            vld[n]  = (cnt_q[n] != '0);
        end
    end

    // Accept decision: full queues stall, nonexistent threads are swallowed
    always_comb begin
        o_vpu_cmd_ack = 1'b0;
        tgt_full      = 1'b0;
        for (int n = 0; n < NTHR; n++) begin
            if (th_ext == 4'(n)) tgt_full = full[n];
        end
`ifdef VXE_VPU_CMD_BCAST_EN
        if (i_vpu_cmd_th == 3'h7)
            o_vpu_cmd_ack = i_vpu_cmd_sel & ~(|full);
        else if (th_valid)
            o_vpu_cmd_ack = i_vpu_cmd_sel & ~tgt_full;
        else
            o_vpu_cmd_ack = i_vpu_cmd_sel;
`else
        if (th_valid)
            o_vpu_cmd_ack = i_vpu_cmd_sel & ~tgt_full;
        else
            o_vpu_cmd_ack = i_vpu_cmd_sel;
`endif
    end

    // Per-queue push/pop strobes and next counts; sticky error on bad thread id
    always_comb begin
        push       = '0;
        pop        = i_th_cmd_rd & vld;
        nonempty_d = '0;
        for (int n = 0; n < NTHR; n++) begin
`ifdef VXE_VPU_CMD_BCAST_EN
            push[n] = xfer & ((i_vpu_cmd_th == 3'h7) | (th_ext == 4'(n)));
`else
            push[n] = xfer & (th_ext == 4'(n));
`endif
            cnt_d[n]      = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
            nonempty_d[n] = (cnt_d[n] != '0);
        end
`ifdef VXE_VPU_CMD_BCAST_EN
        err_d = err_q | (xfer & ~th_valid & (i_vpu_cmd_th != 3'h7));
`else
        err_d = err_q | (xfer & ~th_valid);
`endif
    end

    // Queue storage, pointers, counts and status registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int n = 0; n < NTHR; n++) begin
                cnt_q[n]  <= '0;
                wptr_q[n] <= '0;
                rptr_q[n] <= '0;
                for (int d = 0; d < DEPTH; d++) mem_q[n][d] <= '0;
            end
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int n = 0; n < NTHR; n++) begin
                cnt_q[n] <= cnt_d[n];
                if (push[n]) begin
                    mem_q[n][wptr_q[n]] <= {i_vpu_cmd_op, i_vpu_cmd_pl};
                    wptr_q[n]           <= wptr_q[n] + 1'b1;
                end
                if (pop[n]) rptr_q[n] <= rptr_q[n] + 1'b1;
            end
            busy_q <= |nonempty_d;
            err_q  <= err_d;
        end
    end

    // Head outputs: entry at the read pointer, forced to zero while empty
    always_comb begin
        o_th_cmd_op = '0;
        o_th_cmd_pl = '0;
        for (int n = 0; n < NTHR; n++) begin
            if (vld[n]) begin
                o_th_cmd_op[5*n +: 5]   = mem_q[n][rptr_q[n]].op;
                o_th_cmd_pl[48*n +: 48] = mem_q[n][rptr_q[n]].pl;
            end
        end
    end

    assign o_th_cmd_vld = vld;
    assign o_busy       = busy_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_vxe_vpu_cmd_dispatch.sv
// Testbench for vxe_vpu_cmd_dispatch: an 8-thread and a 4-thread instance
// share clock and reset; directed scenarios with hand-computed expectations.
module tb_vxe_vpu_cmd_dispatch;

    logic clk;
    logic nrst;

    logic          sel8, ack8, busy8, err8;
    logic [4:0]    op8;
    logic [2:0]    th8;
    logic [47:0]   pl8;
    logic [7:0]    vld8, rd8;
    logic [39:0]   hop8;
    logic [383:0]  hpl8;

    logic          sel4, ack4, busy4, err4;
    logic [4:0]    op4;
    logic [2:0]    th4;
    logic [47:0]   pl4;
    logic [3:0]    vld4, rd4;
    logic [19:0]   hop4;
    logic [191:0]  hpl4;

    int errors = 0;
    int checks = 0;

    vxe_vpu_cmd_dispatch #(.NTHR(8), .QDEPTH_POW2(1)) dut8 (
        .clk(clk), .nrst(nrst),
        .i_vpu_cmd_sel(sel8), .o_vpu_cmd_ack(ack8),
        .i_vpu_cmd_op(op8), .i_vpu_cmd_th(th8), .i_vpu_cmd_pl(pl8),
        .o_th_cmd_vld(vld8), .o_th_cmd_op(hop8), .o_th_cmd_pl(hpl8),
        .i_th_cmd_rd(rd8), .o_busy(busy8), .o_err(err8)
    );

    vxe_vpu_cmd_dispatch #(.NTHR(4), .QDEPTH_POW2(1)) dut4 (
        .clk(clk), .nrst(nrst),
        .i_vpu_cmd_sel(sel4), .o_vpu_cmd_ack(ack4),
        .i_vpu_cmd_op(op4), .i_vpu_cmd_th(th4), .i_vpu_cmd_pl(pl4),
        .o_th_cmd_vld(vld4), .o_th_cmd_op(hop4), .o_th_cmd_pl(hpl4),
        .i_th_cmd_rd(rd4), .o_busy(busy4), .o_err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        sel8 = 0; op8 = 0; th8 = 0; pl8 = 0; rd8 = 0;
        sel4 = 0; op4 = 0; th4 = 0; pl4 = 0; rd4 = 0;
        #12;
        checks++; if (vld8 !== 8'h00) begin errors++; $display("FAIL reset_vld8: got %0h expected 0", vld8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %0b expected 0", busy8); end
        checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL reset_err8: got %0b expected 0", err8); end
        checks++; if (hop8 !== 40'h0) begin errors++; $display("FAIL reset_op8: got %0h expected 0", hop8); end
        checks++; if (hpl8 !== 384'h0) begin errors++; $display("FAIL reset_pl8: got nonzero expected 0"); end
        checks++; if (ack8 !== 1'b0) begin errors++; $display("FAIL reset_ack_nosel: got %0b expected 0", ack8); end
        checks++; if (err4 !== 1'b0 || vld4 !== 4'h0) begin errors++; $display("FAIL reset_dut4: got err=%0b vld=%0h expected 0/0", err4, vld4); end
        @(negedge clk);
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic_routing();
        for (int i = 1; i <= 4; i++) begin
            sel8 = 1'b1; op8 = 5'(i); th8 = 3'(i); pl8 = 48'(i);
            #4;
            checks++; if (ack8 !== 1'b1) begin errors++; $display("FAIL route_ack[%0d]: got %0b expected 1", i, ack8); end
            tick();
        end
        sel8 = 1'b0;
        #4;
        checks++; if (vld8 !== 8'b0001_1110) begin errors++; $display("FAIL route_vld: got %b expected 00011110", vld8); end
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL route_busy: got %0b expected 1", busy8); end
        checks++; if (hop8[15 +: 5] !== 5'd3) begin errors++; $display("FAIL route_op3: got %0h expected 3", hop8[15 +: 5]); end
        checks++; if (hpl8[144 +: 48] !== 48'h3) begin errors++; $display("FAIL route_pl3: got %0h expected 3", hpl8[144 +: 48]); end
        checks++; if (hop8[20 +: 5] !== 5'd4) begin errors++; $display("FAIL route_op4: got %0h expected 4", hop8[20 +: 5]); end
        rd8 = 8'h1E;
        tick();
        rd8 = 8'h00;
        #4;
        checks++; if (vld8 !== 8'h00) begin errors++; $display("FAIL route_drain_vld: got %b expected 0", vld8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL route_drain_busy: got %0b expected 0", busy8); end
        tick();
    endtask

    task automatic test_full_backpressure();
        for (int i = 5; i <= 6; i++) begin
            sel8 = 1'b1; th8 = 3'd2; op8 = 5'(i); pl8 = 48'(i);
            #4;
            checks++; if (ack8 !== 1'b1) begin errors++; $display("FAIL full_ack_op%0d: got %0b expected 1", i, ack8); end
            tick();
        end
        op8 = 5'd7; pl8 = 48'd7; rd8 = 8'h04;
        #4;
        checks++; if (ack8 !== 1'b0) begin errors++; $display("FAIL full_ack_third: got %0b expected 0", ack8); end
        checks++; if (hop8[10 +: 5] !== 5'd5) begin errors++; $display("FAIL full_head5: got %0h expected 5", hop8[10 +: 5]); end
        tick();
        rd8 = 8'h00;
        #4;
        checks++; if (ack8 !== 1'b1) begin errors++; $display("FAIL full_ack_after_pop: got %0b expected 1", ack8); end
        checks++; if (hop8[10 +: 5] !== 5'd6) begin errors++; $display("FAIL full_head6: got %0h expected 6", hop8[10 +: 5]); end
        tick();
        sel8 = 1'b0; rd8 = 8'h04;
        #4;
        checks++; if (hop8[10 +: 5] !== 5'd6) begin errors++; $display("FAIL full_head6_hold: got %0h expected 6", hop8[10 +: 5]); end
        tick();
        #4;
        checks++; if (hop8[10 +: 5] !== 5'd7 || hpl8[96 +: 48] !== 48'd7) begin errors++; $display("FAIL full_head7: got op=%0h pl=%0h expected 7/7", hop8[10 +: 5], hpl8[96 +: 48]); end
        tick();
        rd8 = 8'h00;
        #4;
        checks++; if (vld8[2] !== 1'b0 || hop8[10 +: 5] !== 5'd0) begin errors++; $display("FAIL full_empty: got vld=%0b op=%0h expected 0/0", vld8[2], hop8[10 +: 5]); end
        tick();
    endtask

    task automatic test_push_pop();
        sel8 = 1'b1; th8 = 3'd0; op8 = 5'd8; pl8 = 48'h8;
        tick();
        op8 = 5'd9; pl8 = 48'h9; rd8 = 8'h01;
        #4;
        checks++; if (ack8 !== 1'b1 || hop8[0 +: 5] !== 5'd8) begin errors++; $display("FAIL pp_pre: got ack=%0b op=%0h expected 1/8", ack8, hop8[0 +: 5]); end
        tick();
        rd8 = 8'h00; op8 = 5'd10; pl8 = 48'hA;
        #4;
        checks++; if (vld8[0] !== 1'b1 || hop8[0 +: 5] !== 5'd9) begin errors++; $display("FAIL pp_head9: got vld=%0b op=%0h expected 1/9", vld8[0], hop8[0 +: 5]); end
        checks++; if (ack8 !== 1'b1) begin errors++; $display("FAIL pp_count1_ack: got %0b expected 1", ack8); end
        tick();
        op8 = 5'd11;
        #4;
        checks++; if (ack8 !== 1'b0) begin errors++; $display("FAIL pp_count2_full: got %0b expected 0", ack8); end
        sel8 = 1'b0; rd8 = 8'h01;
        tick();
        #4;
        checks++; if (hop8[0 +: 5] !== 5'd10) begin errors++; $display("FAIL pp_head10: got %0h expected a", hop8[0 +: 5]); end
        tick();
        rd8 = 8'h00;
        #4;
        checks++; if (vld8 !== 8'h00) begin errors++; $display("FAIL pp_empty: got %b expected 0", vld8); end
        tick();
    endtask

    task automatic test_bad_thread();
        sel4 = 1'b1; th4 = 3'd5; op4 = 5'd3; pl4 = 48'h33;
        #4;
        checks++; if (ack4 !== 1'b1) begin errors++; $display("FAIL bad_ack: got %0b expected 1", ack4); end
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL bad_err_early: got %0b expected 0", err4); end
        tick();
        sel4 = 1'b0;
        #4;
        checks++; if (vld4 !== 4'h0) begin errors++; $display("FAIL bad_vld: got %b expected 0", vld4); end
        checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %0b expected 1", err4); end
        repeat (3) tick();
        checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %0b expected 1", err4); end
        checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL bad_err8_clean: got %0b expected 0", err8); end
    endtask

`ifndef VXE_VPU_CMD_BCAST_EN
    task automatic test_thread7_route();
        sel8 = 1'b1; th8 = 3'd7; op8 = 5'h15; pl8 = 48'hABC;
        #4;
        checks++; if (ack8 !== 1'b1) begin errors++; $display("FAIL th7_ack: got %0b expected 1", ack8); end
        tick();
        sel8 = 1'b0;
        #4;
        checks++; if (vld8 !== 8'h80) begin errors++; $display("FAIL th7_vld: got %b expected 10000000", vld8); end
        checks++; if (hop8[35 +: 5] !== 5'h15 || hpl8[336 +: 48] !== 48'hABC) begin errors++; $display("FAIL th7_head: got op=%0h pl=%0h expected 15/abc", hop8[35 +: 5], hpl8[336 +: 48]); end
        checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL th7_err: got %0b expected 0", err8); end
        rd8 = 8'h80;
        tick();
        rd8 = 8'h00;
    endtask
`endif

    task automatic test_mid_reset();
        sel8 = 1'b1; th8 = 3'd1; op8 = 5'd1; pl8 = 48'h1;
        tick();
        th8 = 3'd6; op8 = 5'd6;
        tick();
        sel8 = 1'b0;
        #4;
        checks++; if (vld8 !== 8'h42 || busy8 !== 1'b1) begin errors++; $display("FAIL mr_pre: got vld=%b busy=%0b expected 01000010/1", vld8, busy8); end
        #1;
        nrst = 1'b0;
        #1;
        checks++; if (vld8 !== 8'h00) begin errors++; $display("FAIL mr_vld: got %b expected 0", vld8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL mr_busy: got %0b expected 0", busy8); end
        checks++; if (hop8 !== 40'h0) begin errors++; $display("FAIL mr_op: got %0h expected 0", hop8); end
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL mr_err4_clear: got %0b expected 0", err4); end
        @(negedge clk);
        nrst = 1'b1;
        tick();
    endtask

`ifdef VXE_VPU_CMD_BCAST_EN
    task automatic test_broadcast();
        sel4 = 1'b1; th4 = 3'd7; op4 = 5'h1F; pl4 = 48'h7;
        #4;
        checks++; if (ack4 !== 1'b1) begin errors++; $display("FAIL bc_ack: got %0b expected 1", ack4); end
        tick();
        sel4 = 1'b0;
        #4;
        checks++; if (vld4 !== 4'hF) begin errors++; $display("FAIL bc_vld: got %b expected 1111", vld4); end
        for (int n = 0; n < 4; n++) begin
            checks++; if (hop4[5*n +: 5] !== 5'h1F) begin errors++; $display("FAIL bc_op[%0d]: got %0h expected 1f", n, hop4[5*n +: 5]); end
        end
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL bc_err: got %0b expected 0", err4); end
        sel4 = 1'b1; th4 = 3'd1; op4 = 5'd2;
        #4;
        checks++; if (ack4 !== 1'b1) begin errors++; $display("FAIL bc_fill1: got %0b expected 1", ack4); end
        tick();
        th4 = 3'd7;
        #4;
        checks++; if (ack4 !== 1'b0) begin errors++; $display("FAIL bc_full_ack: got %0b expected 0", ack4); end
        tick();
        sel4 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_routing();
        test_full_backpressure();
        test_push_pop();
        test_bad_thread();
`ifndef VXE_VPU_CMD_BCAST_EN
        test_thread7_route();
`endif
        test_mid_reset();
`ifdef VXE_VPU_CMD_BCAST_EN
        test_broadcast();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
